// File: rtl/cache_pkg.sv
// Shared constants and types for the lru_cache_ctrl lookup/fill sequencer.
package cache_pkg;

  localparam int unsigned NUM_LINES = 4;
  localparam int unsigned LINE_W    = $clog2(NUM_LINES);

  typedef logic [LINE_W-1:0] line_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    FILL,
    RESP
  } state_e;

endpackage

// File: rtl/lru_age_tracker.sv
// True-LRU age registers: age 0 is most recent, age NUM_LINES-1 is the eviction candidate.
module lru_age_tracker
  import cache_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      touch,
  input  line_idx_t touch_line,
  output line_idx_t lru_line
);

  line_idx_t age_q [NUM_LINES];
  line_idx_t age_d [NUM_LINES];
  line_idx_t old_age;

  assign old_age = age_q[touch_line];

  // Only lines younger than the touched one age, so the set stays a permutation.
  always_comb begin
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      age_d[i] = age_q[i];
      if (touch) begin
        if (line_idx_t'(i) == touch_line) begin
          age_d[i] = '0;
        end else if (age_q[i] < old_age) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    lru_line = '0;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      if (age_q[i] == line_idx_t'(NUM_LINES - 1)) begin
        lru_line = line_idx_t'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        age_q[i] <= line_idx_t'(NUM_LINES - 1 - i);
      end
    end else begin
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

endmodule

// File: rtl/lru_cache_ctrl.sv
// Lookup/fill sequencer for a 4-line fully associative cache with true-LRU replacement.
// Define CACHE_STATS_EN to add saturating hit/miss counters and the stats_clr input.
module lru_cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned TAG_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_hit,
  output logic [LINE_W-1:0] resp_line,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [TAG_W-1:0]  mem_req_tag,
  input  logic              mem_fill_valid,
  output logic [LINE_W-1:0] cache_line,
  output logic              cache_we
`ifdef CACHE_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  state_e                 state_q, state_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  line_idx_t              line_q, line_d;
  logic                   hit_q, hit_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]       tags_q [NUM_LINES];
  logic [TAG_W-1:0]       tags_d [NUM_LINES];

  logic      match;
  line_idx_t match_line;
  logic      free;
  line_idx_t free_line;
  logic      touch;
  line_idx_t touch_line;
  line_idx_t lru_line;

  lru_age_tracker u_age (
    .clk        (clk),
    .rst_n      (rst_n),
    .touch      (touch),
    .touch_line (touch_line),
    .lru_line   (lru_line)
  );

  always_comb begin
    match      = 1'b0;
    match_line = '0;
    free       = 1'b0;
    free_line  = '0;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      if (valid_q[i] && (tags_q[i] == tag_q)) begin
        match      = 1'b1;
        match_line = line_idx_t'(i);
      end
      if (!valid_q[i] && !free) begin
        free      = 1'b1;
        free_line = line_idx_t'(i);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    tag_d         = tag_q;
    line_d        = line_q;
    hit_d         = hit_q;
    valid_d       = valid_q;
    tags_d        = tags_q;
    touch         = 1'b0;
    touch_line    = line_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem_req_valid = 1'b0;
    cache_we      = 1'b0;
    cache_line    = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          tag_d   = req_tag;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (match) begin
          line_d     = match_line;
          hit_d      = 1'b1;
          touch      = 1'b1;
          touch_line = match_line;
          cache_line = match_line;
          state_d    = RESP;
        end else begin
          line_d  = free ? free_line : lru_line;
          hit_d   = 1'b0;
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (mem_fill_valid) state_d = FILL;
      end
      FILL: begin
        cache_we        = 1'b1;
        cache_line      = line_q;
        tags_d[line_q]  = tag_q;
        valid_d[line_q] = 1'b1;
        touch           = 1'b1;
        state_d         = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        cache_line = line_q;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_hit    = (state_q == RESP) && hit_q;
  assign resp_line   = (state_q == RESP) ? line_q : '0;
  assign mem_req_tag = (state_q == MISS_REQ) ? tag_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tag_q   <= '0;
      line_q  <= '0;
      hit_q   <= 1'b0;
      valid_q <= '0;
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        tags_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
      hit_q   <= hit_d;
      valid_q <= valid_d;
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        tags_q[i] <= tags_d[i];
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  // A clear in the same cycle as a lookup outcome drops that outcome.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (stats_clr) begin
      hit_count_d  = '0;
      miss_count_d = '0;
    end else if (state_q == LOOKUP) begin
      if (match) begin
        if (hit_count_q != '1) hit_count_d = hit_count_q + 16'd1;
      end else begin
        if (miss_count_q != '1) miss_count_d = miss_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
